// File: rtl/wb_as_master_bridge.sv
// wb_as_master_bridge: Wishbone slave that tunnels each access over the AS byte link
module wb_as_master_bridge #(
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  as_data_o,
  output logic        as_dstrb_o,
  input  logic        as_busy_i,
  input  logic [7:0]  as_data_i,
  input  logic        as_dstrb_i,
  output logic        as_busy_o,
  output logic [7:0]  resp_o,
  output logic        stray_o
);
  typedef enum logic [2:0] {IDLE, SEND, RTYPE, RDATA, DONE} state_t;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state_q, state_d;
  logic we_q, we_d;
  logic [15:0] adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [2:0] idx_q, idx_d;
  logic rsel_q, rsel_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [7:0] as_data_q, as_data_d, resp_q, resp_d;
  logic as_dstrb_q, as_dstrb_d, ack_q, ack_d, err_q, err_d, stray_q, stray_d;
  logic tx, rx, last, tmo_hit;
  // Command byte order: opcode, address low/high, then write data low/high
  function automatic logic [7:0] cmd_byte(input logic [2:0] i, input logic we, input logic [15:0] adr,
                                          input logic [15:0] dat);
    return i == 3'd0 ? (we ? 8'h02 : 8'h01) : i == 3'd1 ? adr[7:0] : i == 3'd2 ? adr[15:8] :
           i == 3'd3 ? dat[7:0] : dat[15:8];
  endfunction
  assign as_busy_o  = (state_q == SEND) || (state_q == DONE);
  assign tx         = as_dstrb_q & ~as_busy_i;
  assign rx         = as_dstrb_i & ~as_busy_o;
  assign last       = idx_q == (we_q ? 3'd4 : 3'd2);
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  assign wb_dat_o   = rdat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign as_data_o  = as_data_q;
  assign as_dstrb_o = as_dstrb_q;
  assign resp_o     = resp_q;
  assign stray_o    = stray_q;
  // Next-state logic: serialise the command, then parse the response or time out
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    idx_d      = idx_q;
    rsel_d     = rsel_q;
    tmo_d      = tmo_q;
    as_data_d  = as_data_q;
    as_dstrb_d = as_dstrb_q;
    rdat_d     = rdat_q;
    resp_d     = resp_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    stray_d    = 1'b0;
    case (state_q)
      IDLE: begin
        stray_d = rx;
        if (wb_cyc_i & wb_stb_i) begin
          we_d       = wb_we_i;
          adr_d      = wb_adr_i;
          wdat_d     = wb_dat_i;
          idx_d      = 3'd0;
          as_dstrb_d = 1'b1;
          as_data_d  = cmd_byte(3'd0, wb_we_i, wb_adr_i, wb_dat_i);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx) begin
          idx_d      = idx_q + 3'd1;
          as_data_d  = last ? as_data_q : cmd_byte(idx_q + 3'd1, we_q, adr_q, wdat_q);
          as_dstrb_d = ~last;
          tmo_d      = '0;
          state_d    = last ? RTYPE : SEND;
        end
      end
      RTYPE: begin
        if (rx) begin
          resp_d  = as_data_i;
          tmo_d   = '0;
          rsel_d  = 1'b0;
          state_d = (as_data_i == 8'h01 && !we_q) ? RDATA : DONE;
          ack_d   = (as_data_i == 8'h01) && we_q;
          err_d   = as_data_i != 8'h01;
        end else if (tmo_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RDATA: begin
        if (rx) begin
          tmo_d   = '0;
          rsel_d  = 1'b1;
          rdat_d  = rsel_q ? {as_data_i, rdat_q[7:0]} : {rdat_q[15:8], as_data_i};
          state_d = rsel_q ? DONE : RDATA;
          ack_d   = rsel_q;
        end else if (tmo_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs; reset aborts any transaction silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      idx_q      <= '0;
      rsel_q     <= 1'b0;
      tmo_q      <= '0;
      as_data_q  <= '0;
      as_dstrb_q <= 1'b0;
      rdat_q     <= '0;
      resp_q     <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      idx_q      <= idx_d;
      rsel_q     <= rsel_d;
      tmo_q      <= tmo_d;
      as_data_q  <= as_data_d;
      as_dstrb_q <= as_dstrb_d;
      rdat_q     <= rdat_d;
      resp_q     <= resp_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      stray_q    <= stray_d;
    end
  end
endmodule

// File: tb/tb_wb_as_master_bridge.sv
// tb_wb_as_master_bridge: randomized transactions against a transaction-level model of the bridge
module tb_wb_as_master_bridge;
  logic clk = 1'b0, reset = 1'b0;
  logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [15:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic wb_ack_o, wb_err_o, as_dstrb_o, as_busy_o, stray_o;
  logic [7:0] as_data_o, resp_o;
  logic as_busy_i = 1'b0, as_dstrb_i = 1'b0;
  logic [7:0] as_data_i = '0;
  int n_chk = 0, n_fail = 0;
  logic [15:0] m_dat = '0;
  logic [7:0] m_resp = '0;
  wb_as_master_bridge #(.TIMEOUT(16), .TIMEOUT_W(5)) dut (
    .clk(clk), .reset(reset), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .as_data_o(as_data_o), .as_dstrb_o(as_dstrb_o), .as_busy_i(as_busy_i),
    .as_data_i(as_data_i), .as_dstrb_i(as_dstrb_i), .as_busy_o(as_busy_o), .resp_o(resp_o),
    .stray_o(stray_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic resp_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    as_data_i = b;
    as_dstrb_i = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      acc = !as_busy_o;
      @(negedge clk);
    end
    as_dstrb_i = 1'b0;
    chk("resp_accept", acc, 1);
  endtask
  task automatic check_reset_outputs();
    chk("rst_dstrb", as_dstrb_o, 0);
    chk("rst_data", as_data_o, 0);
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_err", wb_err_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_resp", resp_o, 0);
    chk("rst_stray", stray_o, 0);
    chk("rst_busy", as_busy_o, 0);
  endtask
  // kind: 0 = reply ok (read carries b1 low, b2 high), 1 = error type b0, 2 = silent remote
  task automatic txn(input logic we, input logic [15:0] adr, input logic [15:0] dat, input int kind,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input int busy_pct, input int stall_idx);
    logic [7:0] exp[$];
    int got, st, n;
    got = 0;
    st = 0;
    exp.push_back(we ? 8'h02 : 8'h01);
    exp.push_back(adr[7:0]);
    exp.push_back(adr[15:8]);
    if (we) begin
      exp.push_back(dat[7:0]);
      exp.push_back(dat[15:8]);
    end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int c = 0; c < 300 && got < exp.size(); c++) begin
      if (got == stall_idx && st < 7) begin
        as_busy_i = 1'b1;
        st++;
        chk("hold_data", as_data_o, exp[got]);
        chk("hold_stb", as_dstrb_o, 1);
      end else begin
        as_busy_i = $urandom_range(99) < busy_pct;
      end
      if (as_dstrb_o && !as_busy_i) begin
        chk("cmd_byte", as_data_o, exp[got]);
        got++;
      end
      @(negedge clk);
    end
    as_busy_i = 1'b0;
    chk("cmd_count", got, exp.size());
    chk("cmd_idle", as_dstrb_o, 0);
    if (kind != 2) begin
      repeat ($urandom_range(3)) @(negedge clk);
      resp_byte(kind == 0 ? 8'h01 : b0);
      if (kind == 0 && !we) begin
        repeat ($urandom_range(3)) @(negedge clk);
        resp_byte(b1);
        repeat ($urandom_range(3)) @(negedge clk);
        resp_byte(b2);
      end
    end
    n = 0;
    while (!wb_ack_o && !wb_err_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (kind == 2) chk("tmo_latency_ok", (n >= 15 && n <= 17), 1);
    else chk("done_latency", n, 0);
    if (kind != 2) m_resp = kind == 0 ? 8'h01 : b0;
    if (kind == 0 && !we) m_dat = {b2, b1};
    chk("ack", wb_ack_o, kind == 0);
    chk("err", wb_err_o, kind != 0);
    chk("resp", resp_o, m_resp);
    chk("rdata", wb_dat_o, m_dat);
    @(negedge clk);
    chk("ack_pulse", wb_ack_o, 0);
    chk("err_pulse", wb_err_o, 0);
  endtask
  initial begin
    logic [7:0] errs[4];
    errs = '{8'hFD, 8'hFE, 8'hFF, 8'h08};
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clk);
    txn(1'b1, 16'h1234, 16'hBEEF, 0, 8'h00, 8'h00, 8'h00, 0, -1);
    txn(1'b0, 16'h0042, 16'h0000, 0, 8'h00, 8'hCD, 8'hAB, 0, -1);
    txn(1'b0, 16'h0042, 16'h0000, 1, 8'hFE, 8'h00, 8'h00, 0, -1);
    txn(1'b0, 16'h0100, 16'h0000, 0, 8'h00, 8'h11, 8'h22, 0, -1);
    txn(1'b1, 16'h1234, 16'hBEEF, 0, 8'h00, 8'h00, 8'h00, 0, 2);
    txn(1'b0, 16'h0007, 16'h0000, 2, 8'h00, 8'h00, 8'h00, 0, -1);
    resp_byte(8'h01);
    chk("stray_pulse", stray_o, 1);
    chk("stray_resp_kept", resp_o, m_resp);
    @(negedge clk);
    chk("stray_clear", stray_o, 0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 16'h5678; wb_dat_i = 16'h9ABC;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_send_byte", as_data_o, 8'h56);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    m_dat = '0;
    m_resp = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    txn(1'b0, 16'h00A5, 16'h0000, 0, 8'h00, 8'h5A, 8'hC3, 0, -1);
    for (int t = 0; t < 30; t++) begin
      int r, kind;
      logic [7:0] eb;
      r = $urandom_range(9);
      kind = r == 0 ? 2 : (r <= 2 ? 1 : 0);
      eb = $urandom_range(1) ? errs[$urandom_range(3)] : 8'($urandom_range(255));
      if (eb == 8'h01) eb = 8'h80;
      txn(1'($urandom_range(1)), 16'($urandom), 16'($urandom), kind, eb, 8'($urandom), 8'($urandom),
          30, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
